// File: rtl/mem_write_queue_if.sv
// Handshake, drain and lookup signals between a write producer and the coalescing
// write queue that feeds a memory write port.
interface mem_write_queue_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned QDEPTH = 4
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    in_addr;
    logic [WIDTH-1:0] in_data;
    logic             mem_ready;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    lookup_addr;
    logic             lookup_hit;
    logic [WIDTH-1:0] lookup_data;
    logic [CW-1:0]    count;
    logic             empty;

    modport master (
        output in_valid, in_addr, in_data, mem_ready, lookup_addr,
        input  in_ready, we, waddr, wdata, lookup_hit, lookup_data, count, empty
    );

    modport slave (
        input  in_valid, in_addr, in_data, mem_ready, lookup_addr,
        output in_ready, we, waddr, wdata, lookup_hit, lookup_data, count, empty
    );
endinterface

// File: rtl/mem_write_queue.sv
// Coalescing circular write queue in front of a memory write port, draining one entry
// per cycle and offering a combinational forwarding lookup over the queued entries.
module mem_write_queue #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned QDEPTH = 4
) (
    input logic               clock,
    input logic               reset,
    mem_write_queue_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(QDEPTH);

    typedef logic [PW-1:0] idx_t;
    typedef logic [PW:0]   ptr_t;

    logic [QDEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]     addr_q [QDEPTH];
    logic [AW-1:0]     addr_d [QDEPTH];
    logic [WIDTH-1:0]  data_q [QDEPTH];
    logic [WIDTH-1:0]  data_d [QDEPTH];
    ptr_t              head_q, head_d, tail_q, tail_d;

    idx_t head_idx, tail_idx, co_idx;
    logic is_empty, is_full, drain, accept, co_hit;

    assign head_idx = head_q[PW-1:0];
    assign tail_idx = tail_q[PW-1:0];
    assign is_empty = (head_q == tail_q);
    assign is_full  = (head_idx == tail_idx) && (head_q[PW] != tail_q[PW]);
    assign drain    = !is_empty && bus.mem_ready;
    assign accept   = bus.in_valid && bus.in_ready;

    assign bus.in_ready = !is_full || drain;
    assign bus.we       = drain;
    assign bus.waddr    = drain ? addr_q[head_idx] : '0;
    assign bus.wdata    = drain ? data_q[head_idx] : '0;
    assign bus.count    = tail_q - head_q;
    assign bus.empty    = is_empty;

    // The head entry leaving this cycle is excluded so a rewrite lands behind it in order.
    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == bus.in_addr) && !(drain && (idx_t'(i) == head_idx)))
            begin
                co_hit = 1'b1;
                co_idx = idx_t'(i);
            end
        end
    end

    always_comb begin
        bus.lookup_hit  = 1'b0;
        bus.lookup_data = '0;
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == bus.lookup_addr)) begin
                bus.lookup_hit  = 1'b1;
                bus.lookup_data = data_q[i];
            end
        end
    end

    // Allocation is applied after the drain so a full queue reuses the slot just freed.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (drain) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + 1'b1;
        end
        if (accept) begin
            if (co_hit) begin
                data_d[co_idx] = bus.in_data;
            end else begin
                valid_d[tail_idx] = 1'b1;
                addr_d[tail_idx]  = bus.in_addr;
                data_d[tail_idx]  = bus.in_data;
                tail_d            = tail_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end
endmodule
